// File: rtl/mfe_window_engine_if.sv
// Host, image-memory and result-memory signals of the 3x3 window filter engine.
// The master modport is the engine side; the slave modport is the host/memory side.
interface mfe_window_engine_if #(
  parameter int DW = 8,
  parameter int XW = 7,
  parameter int YW = 7
);
  logic                 ready;
  logic [1:0]           mode;
  logic                 busy;
  logic                 done;
  logic [XW+YW-1:0]     iaddr;
  logic [DW-1:0]        idata;
  logic [XW+YW-1:0]     addr;
  logic [DW-1:0]        data_wr;
  logic                 wen;

  modport master (
    input  ready, mode, idata,
    output busy, done, iaddr, addr, data_wr, wen
  );

  modport slave (
    output ready, mode, idata,
    input  busy, done, iaddr, addr, data_wr, wen
  );
endinterface

// File: rtl/mfe_window_engine.sv
// 3x3 median/min/max window filter over a 2**XW x 2**YW image with column reuse.
// Borders are zero-padded; define MFE_BORDER_REPLICATE_EN to clamp to the nearest pixel.
module mfe_window_engine #(
  parameter int DW = 8,
  parameter int XW = 7,
  parameter int YW = 7
) (
  input  logic                clk,
  input  logic                reset,
  mfe_window_engine_if.master bus
);

  localparam int AW = XW + YW;
  localparam logic [XW-1:0] X_LAST = '1;
  localparam logic [YW-1:0] Y_LAST = '1;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_RES, SHIFT, SORT, WR} state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] x, x_nxt, x_inc, rd_col;
  logic [YW-1:0] y, y_nxt, rd_y;
  logic [1:0]    rd_row, rd_row_nxt, mode_q, mode_nxt;
  logic          rd_tgt_c, rd_tgt_c_nxt, rd_real, load_copy, is_median;
  logic [2:0]    step, step_nxt, last_step;
  logic [DW-1:0] win_l [3], win_c [3], win_r [3];
  logic [DW-1:0] l_nxt [3], c_nxt [3], r_nxt [3];
  logic [DW-1:0] s [9], s_nxt [9];
  logic [DW-1:0] pix_in, op_a, op_b, op_c, t_lo, t_hi, t_m, lo, mid, hi, result;
  logic [3:0]    ia, ib, ic;
  logic          busy_q, busy_nxt, done_q, done_nxt, wen_q, wen_nxt;
  logic [AW-1:0] addr_q, addr_nxt, iaddr_q, iaddr_cur;
  logic [DW-1:0] data_q, data_nxt;

  assign x_inc     = x + XW'(1);
  assign rd_col    = rd_tgt_c ? x : x_inc;
  assign is_median = (mode_q != 2'd1) && (mode_q != 2'd2);
  assign last_step = is_median ? 3'd6 : 3'd5;
  assign pix_in    = rd_real ? bus.idata : '0;
  // Min settles in element 0 after the first column sort; max leaves the sorter on the last column sort.
  assign result    = (mode_q == 2'd1) ? s[0] : (mode_q == 2'd2) ? hi : mid;

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wen     = wen_q;
  assign bus.addr    = addr_q;
  assign bus.data_wr = data_q;
  assign bus.iaddr   = iaddr_cur;

  // Row of the current read; rows outside the image either pad with zero or clamp to y.
  always_comb begin
    rd_y    = y;
    rd_real = 1'b1;
    if (rd_row == 2'd0) begin
      if (y == '0) rd_real = 1'b0;
      else         rd_y = y - YW'(1);
    end else if (rd_row == 2'd2) begin
      if (y == Y_LAST) rd_real = 1'b0;
      else             rd_y = y + YW'(1);
    end
`ifdef MFE_BORDER_REPLICATE_EN
    rd_real = 1'b1;
`endif
  end

  // Shared 3-input sorter: rows, then columns, then the anti-diagonal.
  always_comb begin
    case (step)
      3'd0:    {ia, ib, ic} = {4'd0, 4'd1, 4'd2};
      3'd1:    {ia, ib, ic} = {4'd3, 4'd4, 4'd5};
      3'd2:    {ia, ib, ic} = {4'd6, 4'd7, 4'd8};
      3'd3:    {ia, ib, ic} = {4'd0, 4'd3, 4'd6};
      3'd4:    {ia, ib, ic} = {4'd1, 4'd4, 4'd7};
      3'd5:    {ia, ib, ic} = {4'd2, 4'd5, 4'd8};
      3'd6:    {ia, ib, ic} = {4'd2, 4'd4, 4'd6};
      default: {ia, ib, ic} = {4'd0, 4'd1, 4'd2};
    endcase
    op_a = '0;
    op_b = '0;
    op_c = '0;
    for (int k = 0; k < 9; k++) begin
      if (ia == 4'(k)) op_a = s[k];
      if (ib == 4'(k)) op_b = s[k];
      if (ic == 4'(k)) op_c = s[k];
    end
    t_lo = (op_b < op_a) ? op_b : op_a;
    t_hi = (op_b < op_a) ? op_a : op_b;
    lo   = (op_c < t_lo) ? op_c : t_lo;
    t_m  = (op_c < t_lo) ? t_lo : op_c;
    mid  = (t_m < t_hi) ? t_m : t_hi;
    hi   = (t_m < t_hi) ? t_hi : t_m;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    x_nxt        = x;
    y_nxt        = y;
    rd_row_nxt   = rd_row;
    rd_tgt_c_nxt = rd_tgt_c;
    mode_nxt     = mode_q;
    step_nxt     = step;
    l_nxt        = win_l;
    c_nxt        = win_c;
    r_nxt        = win_r;
    s_nxt        = s;
    load_copy    = 1'b0;
    busy_nxt     = busy_q;
    done_nxt     = 1'b0;
    wen_nxt      = 1'b0;
    addr_nxt     = addr_q;
    data_nxt     = data_q;
    iaddr_cur    = iaddr_q;
    case (state)
      IDLE: begin
        if (bus.ready) begin
          mode_nxt     = bus.mode;
          x_nxt        = '0;
          y_nxt        = '0;
          rd_row_nxt   = 2'd0;
          rd_tgt_c_nxt = 1'b1;
          l_nxt        = '{default: '0};
          busy_nxt     = 1'b1;
          state_nxt    = RD_REQ;
        end
      end
      RD_REQ: begin
        if (rd_real) iaddr_cur = {rd_y, rd_col};
        state_nxt = RD_RES;
      end
      RD_RES: begin
        for (int r = 0; r < 3; r++) begin
          if (rd_row == 2'(r)) begin
            if (rd_tgt_c) c_nxt[r] = pix_in;
            else          r_nxt[r] = pix_in;
          end
        end
        if (rd_row != 2'd2) begin
          rd_row_nxt = rd_row + 2'd1;
          state_nxt  = RD_REQ;
        end else begin
          rd_row_nxt = 2'd0;
          if (!rd_tgt_c) begin
            load_copy = 1'b1;
            step_nxt  = 3'd0;
            state_nxt = SORT;
          end else begin
`ifdef MFE_BORDER_REPLICATE_EN
            state_nxt    = SHIFT;
`else
            rd_tgt_c_nxt = 1'b0;
            state_nxt    = RD_REQ;
`endif
          end
        end
      end
      SHIFT: begin
        // Also used at row start in replicate mode to copy column 0 into the left column.
        l_nxt = win_c;
        if (rd_tgt_c) begin
          rd_tgt_c_nxt = 1'b0;
          state_nxt    = RD_REQ;
        end else begin
          c_nxt = win_r;
`ifdef MFE_BORDER_REPLICATE_EN
          r_nxt = win_r;
`else
          r_nxt = '{default: '0};
`endif
          load_copy = 1'b1;
          step_nxt  = 3'd0;
          state_nxt = SORT;
        end
      end
      SORT: begin
        for (int k = 0; k < 9; k++) begin
          if (ia == 4'(k)) s_nxt[k] = lo;
          if (ib == 4'(k)) s_nxt[k] = mid;
          if (ic == 4'(k)) s_nxt[k] = hi;
        end
        step_nxt = step + 3'd1;
        if (step == last_step) begin
          wen_nxt   = 1'b1;
          addr_nxt  = {y, x};
          data_nxt  = result;
          state_nxt = WR;
        end
      end
      WR: begin
        if (x == X_LAST) begin
          if (y == Y_LAST) begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            x_nxt        = '0;
            y_nxt        = y + YW'(1);
            l_nxt        = '{default: '0};
            rd_tgt_c_nxt = 1'b1;
            state_nxt    = RD_REQ;
          end
        end else begin
          x_nxt        = x_inc;
          rd_tgt_c_nxt = 1'b0;
          if (x_inc == X_LAST) begin
            state_nxt = SHIFT;
          end else begin
            l_nxt     = win_c;
            c_nxt     = win_r;
            state_nxt = RD_REQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // The sorter works on a snapshot so the window columns survive for reuse.
    if (load_copy) begin
      for (int r = 0; r < 3; r++) begin
        s_nxt[3*r]     = l_nxt[r];
        s_nxt[3*r + 1] = c_nxt[r];
        s_nxt[3*r + 2] = r_nxt[r];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      rd_row   <= 2'd0;
      rd_tgt_c <= 1'b0;
      mode_q   <= 2'd0;
      step     <= 3'd0;
      win_l    <= '{default: '0};
      win_c    <= '{default: '0};
      win_r    <= '{default: '0};
      s        <= '{default: '0};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      iaddr_q  <= '0;
    end else begin
      x        <= x_nxt;
      y        <= y_nxt;
      rd_row   <= rd_row_nxt;
      rd_tgt_c <= rd_tgt_c_nxt;
      mode_q   <= mode_nxt;
      step     <= step_nxt;
      win_l    <= l_nxt;
      win_c    <= c_nxt;
      win_r    <= r_nxt;
      s        <= s_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      wen_q    <= wen_nxt;
      addr_q   <= addr_nxt;
      data_q   <= data_nxt;
      iaddr_q  <= iaddr_cur;
    end
  end

endmodule

// File: tb/tb_mfe_window_engine.sv
// Bench for mfe_window_engine on a 4x4 image: every write is compared with a sorted-window
// reference model, along with write order, per-pixel cycle spacing, busy/done and reset behaviour.
module tb_mfe_window_engine;

  localparam int DW = 8;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
`ifdef MFE_BORDER_REPLICATE_EN
  localparam int          ROW_START_EXTRA = 1;
  localparam logic [7:0]  CORNER_FLAT     = 8'h80;
`else
  localparam int          ROW_START_EXTRA = 0;
  localparam logic [7:0]  CORNER_FLAT     = 8'h00;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mfe_window_engine_if #(.DW(DW), .XW(XW), .YW(YW)) bus ();

  mfe_window_engine #(.DW(DW), .XW(XW), .YW(YW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] img [N];
  logic [7:0] got [N];
  int vectors_applied = 0;
  int miscompares     = 0;

  always @(posedge clk) bus.idata <= img[bus.iaddr];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors_applied++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: gather the 3x3 neighbourhood with the border rule, sort it, pick by mode.
  function automatic logic [7:0] ref_pixel(input int px, input int py, input logic [1:0] m);
    int v [9];
    int k, xx, yy, t;
    k = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xx = px + dx;
        yy = py + dy;
`ifdef MFE_BORDER_REPLICATE_EN
        if (xx < 0) xx = 0;
        if (xx >= W) xx = W - 1;
        if (yy < 0) yy = 0;
        if (yy >= H) yy = H - 1;
        v[k] = int'(img[yy*W + xx]);
`else
        if (xx < 0 || xx >= W || yy < 0 || yy >= H) v[k] = 0;
        else v[k] = int'(img[yy*W + xx]);
`endif
        k++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    case (m)
      2'd1:    return 8'(v[0]);
      2'd2:    return 8'(v[8]);
      default: return 8'(v[4]);
    endcase
  endfunction

  // Cycles from the previous write to the write of a pixel in column px.
  function automatic int ref_gap(input int px, input logic [1:0] m);
    int g;
    if (px == 0)          g = 20 + ROW_START_EXTRA;
    else if (px == W - 1) g = 9;
    else                  g = 14;
    if (m == 2'd1 || m == 2'd2) g = g - 1;
    return g;
  endfunction

  task automatic applyStimulus(input logic [1:0] m, input bit hold_ready);
    @(negedge clk);
    bus.mode  = m;
    bus.ready = 1'b1;
    @(negedge clk);
    if (!hold_ready) bus.ready = 1'b0;
    checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic collectFrame(input string tag, input logic [1:0] m, input bit scramble);
    logic [7:0] exp_px [N];
    int n_wr, n_done, cyc, last_wr;
    n_wr = 0; n_done = 0; cyc = 0; last_wr = 0;
    for (int p = 0; p < N; p++) exp_px[p] = ref_pixel(p % W, p / W, m);
    while (n_done == 0 && cyc < 2000) begin
      if (scramble) bus.mode = 2'($urandom);
      @(negedge clk);
      cyc++;
      if (bus.wen === 1'b1) begin
        if (n_wr < N) begin
          checkOutput($sformatf("%s_addr%0d", tag, n_wr), 32'(bus.addr), 32'(n_wr));
          checkOutput($sformatf("%s_data%0d", tag, n_wr), 32'(bus.data_wr), 32'(exp_px[n_wr]));
          if (n_wr > 0)
            checkOutput($sformatf("%s_gap%0d", tag, n_wr), 32'(cyc - last_wr), 32'(ref_gap(n_wr % W, m)));
          got[n_wr] = bus.data_wr;
        end
        n_wr++;
        last_wr = cyc;
      end
      if (bus.done === 1'b1) begin
        n_done++;
        bus.ready = 1'b0;
      end
    end
    checkOutput({tag, "_writes"}, 32'(n_wr), 32'(N));
    checkOutput({tag, "_done_seen"}, 32'(n_done), 32'd1);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_wen_after"}, 32'(bus.wen), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [1:0] m;
    bus.ready = 1'b0;
    bus.mode  = 2'd0;
    reset     = 1'b1;
    for (int i = 0; i < N; i++) begin img[i] = 8'h00; got[i] = 8'h00; end
    repeat (2) @(negedge clk);
    checkOutput("rst_busy",  32'(bus.busy),    32'd0);
    checkOutput("rst_done",  32'(bus.done),    32'd0);
    checkOutput("rst_wen",   32'(bus.wen),     32'd0);
    checkOutput("rst_iaddr", 32'(bus.iaddr),   32'd0);
    checkOutput("rst_addr",  32'(bus.addr),    32'd0);
    checkOutput("rst_data",  32'(bus.data_wr), 32'd0);
    reset = 1'b0;

    $display("[TB] flat 0x80 image, median");
    for (int i = 0; i < N; i++) img[i] = 8'h80;
    applyStimulus(2'd0, 1'b0);
    collectFrame("flat", 2'd0, 1'b0);
    checkOutput("flat_corner", 32'(got[0]), 32'(CORNER_FLAT));
    checkOutput("flat_edge",   32'(got[1]), 32'h80);
    checkOutput("flat_inner",  32'(got[5]), 32'h80);

    $display("[TB] ramp image, min and max");
    for (int i = 0; i < N; i++) img[i] = 8'(i);
    applyStimulus(2'd1, 1'b0);
    collectFrame("ramp_min", 2'd1, 1'b0);
    checkOutput("ramp_min_11", 32'(got[5]), 32'h00);
    applyStimulus(2'd2, 1'b0);
    collectFrame("ramp_max", 2'd2, 1'b0);
    checkOutput("ramp_max_11", 32'(got[5]), 32'h0A);

    $display("[TB] fixed 1..9 window at (1,1), median via mode 0 and mode 3");
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    img[0] = 8'd9; img[1] = 8'd1; img[2]  = 8'd8;
    img[4] = 8'd2; img[5] = 8'd7; img[6]  = 8'd3;
    img[8] = 8'd6; img[9] = 8'd4; img[10] = 8'd5;
    applyStimulus(2'd0, 1'b0);
    collectFrame("win_m0", 2'd0, 1'b0);
    checkOutput("win_m0_11", 32'(got[5]), 32'd5);
    applyStimulus(2'd3, 1'b0);
    collectFrame("win_m3", 2'd3, 1'b1);
    checkOutput("win_m3_11", 32'(got[5]), 32'd5);

    $display("[TB] reset during the sort of pixel (2,1)");
    applyStimulus(2'd0, 1'b0);
    cyc = 0;
    while (!(bus.wen === 1'b1 && bus.addr == 4'd5) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("abort_reached_px5", 32'(cyc < 1000), 32'd1);
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_wen",  32'(bus.wen),  32'd0);
    checkOutput("abort_addr", 32'(bus.addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("abort_idle_busy", 32'(bus.busy), 32'd0);
    m = 2'($urandom);
    applyStimulus(m, 1'b0);
    collectFrame("after_abort", m, 1'b0);

    $display("[TB] ready held high for a whole frame");
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    m = 2'($urandom);
    applyStimulus(m, 1'b1);
    collectFrame("hold_ready", m, 1'b0);

    $display("[TB] random images and modes");
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 3) == 0 ? 8'h00 : $urandom);
      m = 2'($urandom);
      applyStimulus(m, 1'b0);
      collectFrame($sformatf("rand%0d", f), m, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
